prefetch_unit: RTL and testbench
================================

# prefetch_unit

Bus-side instruction prefetcher for the BIU. It computes physical fetch addresses from CS:IP and runs word-wide read cycles on the internal memory bus whenever the instruction queue has room. It pushes the returned bytes one per cycle into the byte-wide instruction queue FIFO. It sits directly upstream of that queue and yields the bus to execution-unit transfers; on a jump it flushes and restarts at the new CS:IP.

## Interface
- RESET_CS, 16'hFFFF, CS value loaded at reset
- RESET_IP, 16'h0000, IP value loaded at reset
- QUEUE_FREE_WIDTH, 3, width of q_free

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- flush  in  1  one-cycle pulse: discard fetch stream, restart at new_cs:new_ip
- new_cs  in  16  CS loaded on flush
- new_ip  in  16  IP loaded on flush
- eu_bus_request  in  1  EU wants the bus; blocks new prefetch starts
- bus_request  out  1  read cycle in progress
- bus_address  out  20  word-aligned physical address (bit 0 always 0)
- bus_ready  in  1  bus completes cycle; bus_read_data valid this cycle
- bus_read_data  in  16  [7:0] = even byte, [15:8] = odd byte
- q_free  in  QUEUE_FREE_WIDTH  free byte slots in the instruction queue
- q_write_enable  out  1  push q_write_data into the queue this cycle
- q_write_data  out  8  byte to push
- fetch_ip  out  16  IP of the next byte to be fetched
- busy  out  1  state != IDLE

## Operation
- Physical address: ({cs,4'b0} + {4'b0,ip}) mod 2^20. bus_address = that value with bit 0 cleared.
- IP advances mod 2^16 (wraps inside the segment); CS never changes except on flush/reset.
- States: IDLE, REQUEST, PUSH_LO, PUSH_HI, DRAIN.
- IDLE -> REQUEST when q_free >= 2, !eu_bus_request, !flush. bus_address is latched on entry and held stable.
- REQUEST: bus_request=1. On bus_ready: capture bus_read_data. If ip[0]==0, go PUSH_LO; otherwise go PUSH_HI (odd start pushes only the high byte).
- PUSH_LO: q_write_enable=1, data = low byte, ip += 1, then PUSH_HI.
- PUSH_HI: q_write_enable=1, data = high byte, ip += 1, then IDLE.
- Fetches from an even IP push 2 bytes; fetches from an odd IP push 1 byte. The q_free >= 2 check guarantees no overflow, because the consumer only frees slots.
- Flush (highest priority after reset), in any state: cs<=new_cs, ip<=new_ip.
  - In IDLE/PUSH_*: q_write_enable is forced 0 that cycle (combinational gate) and the next state is IDLE.
  - In REQUEST with !bus_ready: go to DRAIN. The bus cycle cannot be aborted, so bus_request is held until bus_ready, the data is discarded, then the state goes to IDLE.
  - In REQUEST with bus_ready the same cycle: the data is discarded and the next state is IDLE.
  - In DRAIN: the new CS:IP is loaded and the block stays in DRAIN.
- The top level clears the queue with the same flush pulse; this block does not track queue contents.
- eu_bus_request only prevents IDLE->REQUEST; an in-flight cycle completes.

## Timing
- Reset values: state IDLE, cs=RESET_CS, ip=RESET_IP, bus_request=0, bus_address=0, q_write_enable=0, q_write_data=0, busy=0, fetch_ip=RESET_IP.
- bus_request/bus_address are registered. They rise one cycle after the IDLE start condition holds.
- Read data is registered at bus_ready. The first push occurs the cycle after bus_ready.
- Even fetch, zero wait states: start condition at cycle 0, bus_request 1..1, pushes at cycles 2 and 3, IDLE at 4. The earliest next bus_request is at cycle 5.
- fetch_ip updates on the posedge ending each push cycle.
- Reset mid-operation: bus_request drops on the next edge; any pending push is lost.

## Test plan
- Reset, q_free=6, bus returns 16'hBBAA from FFFF0 with 0 waits -> bus_address=20'hFFFF0, pushes AA then BB, fetch_ip=0002.
- flush new_cs=1234,new_ip=0005; read returns 16'h3322 at 12344 -> one push of 8'h33, fetch_ip=0006. The next fetch is at 12346.
- Flush during REQUEST with 3 wait states -> bus_request held until bus_ready, no q_write_enable. The next fetch uses the new address.
- q_free=1 or eu_bus_request=1 held in IDLE -> bus_request stays 0; raising q_free to 2 starts a fetch the next cycle.
- cs=F000, ip=FFFE, data 16'h2211 -> pushes 11, 22; fetch_ip wraps to 0000. The next address is F0000 (segment wrap, no carry into CS).
- cs=FFFF, ip=0010 -> bus_address=20'h00000 (20-bit wrap).

Source files
------------

// File: rtl/prefetch_unit.sv
// ---------------------------------------------------------------------------
// prefetch_unit
//   Bus-side instruction prefetcher. Forms the physical fetch address from
//   CS:IP, runs word-wide read cycles while the instruction queue has room,
//   and pushes the returned bytes one per cycle into the byte-wide queue.
//   A flush pulse discards the current fetch stream and restarts at the new
//   CS:IP; an in-flight bus cycle is allowed to finish and its data dropped.
//
// Ports
//   clock_i           single clock, all state changes on posedge
//   reset_i           synchronous active-high reset
//   flush_i           one-cycle restart pulse, loads new_cs_i:new_ip_i
//   new_cs_i/new_ip_i CS:IP loaded on flush
//   eu_bus_request_i  execution unit wants the bus; blocks new fetch starts
//   bus_request_o     read cycle in progress (registered)
//   bus_address_o     word-aligned physical address (registered, bit 0 = 0)
//   bus_ready_i       bus completes the cycle; bus_read_data_i valid
//   bus_read_data_i   [7:0] even byte, [15:8] odd byte
//   q_free_i          free byte slots in the instruction queue
//   q_write_enable_o  push q_write_data_o this cycle
//   q_write_data_o    byte to push
//   fetch_ip_o        IP of the next byte to be fetched
//   busy_o            FSM not idle
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for queue room and a free bus
// REQUEST | read cycle on the bus, waiting for bus_ready
// PUSH_LO | pushing the even byte of the captured word
// PUSH_HI | pushing the odd byte of the captured word
// DRAIN   | flushed during a bus cycle; waiting for bus_ready, data dropped
// ---------------------------------------------------------------------------
module prefetch_unit #(
    parameter logic [15:0] RESET_CS         = 16'hFFFF,
    parameter logic [15:0] RESET_IP         = 16'h0000,
    parameter int          QUEUE_FREE_WIDTH = 3
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic [15:0]                 new_cs_i,
    input  logic [15:0]                 new_ip_i,
    input  logic                        eu_bus_request_i,
    output logic                        bus_request_o,
    output logic [19:0]                 bus_address_o,
    input  logic                        bus_ready_i,
    input  logic [15:0]                 bus_read_data_i,
    input  logic [QUEUE_FREE_WIDTH-1:0] q_free_i,
    output logic                        q_write_enable_o,
    output logic [7:0]                  q_write_data_o,
    output logic [15:0]                 fetch_ip_o,
    output logic                        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        PUSH_LO,
        PUSH_HI,
        DRAIN
    } state_t;

    localparam logic [QUEUE_FREE_WIDTH-1:0] MIN_FREE = QUEUE_FREE_WIDTH'(2);

    state_t      state_q;
    logic [15:0] cs_q;
    logic [15:0] ip_q;
    logic [15:0] data_q;
    logic [19:0] addr_q;
    logic        bus_req_q;
    logic [19:0] phys_d;
    logic [19:0] addr_d;
    logic        start_d;

    // 20-bit sum wraps naturally; bit 0 dropped to give the word address
    assign phys_d  = {cs_q, 4'b0000} + {4'b0000, ip_q};
    assign addr_d  = {phys_d[19:1], 1'b0};
    assign start_d = (q_free_i >= MIN_FREE) && !eu_bus_request_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cs_q      <= RESET_CS;
            ip_q      <= RESET_IP;
            data_q    <= 16'h0000;
            addr_q    <= 20'h00000;
            bus_req_q <= 1'b0;
        end else if (flush_i) begin
            cs_q <= new_cs_i;
            ip_q <= new_ip_i;
            case (state_q)
                REQUEST, DRAIN: begin
                    // bus cycle cannot be aborted: hold the request until ready
                    if (bus_ready_i) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q   <= REQUEST;
                        bus_req_q <= 1'b1;
                        addr_q    <= addr_d;
                    end
                end
                REQUEST: begin
                    if (bus_ready_i) begin
                        data_q    <= bus_read_data_i;
                        bus_req_q <= 1'b0;
                        // odd IP only wants the high byte of the word
                        state_q   <= ip_q[0] ? PUSH_HI : PUSH_LO;
                    end
                end
                PUSH_LO: begin
                    ip_q    <= ip_q + 16'd1;
                    state_q <= PUSH_HI;
                end
                PUSH_HI: begin
                    ip_q    <= ip_q + 16'd1;
                    state_q <= IDLE;
                end
                DRAIN: begin
                    if (bus_ready_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    // flush gates the push combinationally so a stale byte never lands
    assign q_write_enable_o = ((state_q == PUSH_LO) || (state_q == PUSH_HI)) && !flush_i;
    assign q_write_data_o   = (state_q == PUSH_LO) ? data_q[7:0]  :
                              (state_q == PUSH_HI) ? data_q[15:8] : 8'h00;
    assign bus_request_o    = bus_req_q;
    assign bus_address_o    = addr_q;
    assign fetch_ip_o       = ip_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_prefetch_unit.sv
module tb_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] new_cs;
    logic [15:0] new_ip;
    logic        eu_bus_request;
    logic        bus_request;
    logic [19:0] bus_address;
    logic        bus_ready;
    logic [15:0] bus_read_data;
    logic [2:0]  q_free;
    logic        q_write_enable;
    logic [7:0]  q_write_data;
    logic [15:0] fetch_ip;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    // bus cycle expectation: {address, read data, wait states}
    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
        int          ws;
    } bus_exp_t;

    bus_exp_t   exp_bus[$];
    logic [7:0] exp_push[$];

    always #5 clock = ~clock;

    prefetch_unit dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .flush_i          (flush),
        .new_cs_i         (new_cs),
        .new_ip_i         (new_ip),
        .eu_bus_request_i (eu_bus_request),
        .bus_request_o    (bus_request),
        .bus_address_o    (bus_address),
        .bus_ready_i      (bus_ready),
        .bus_read_data_i  (bus_read_data),
        .q_free_i         (q_free),
        .q_write_enable_o (q_write_enable),
        .q_write_data_o   (q_write_data),
        .fetch_ip_o       (fetch_ip),
        .busy_o           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // bus responder + address checker
    initial begin
        bit prev_req = 1'b0;
        int cnt = 0;
        bus_exp_t e;
        bus_ready = 1'b0;
        bus_read_data = 16'h0000;
        forever begin
            @(negedge clock);
            if (bus_request && !prev_req) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_bus_cycle", {12'h0, bus_address}, 32'hFFFFFFFF);
                    cnt = 0;
                    bus_read_data = 16'hDEAD;
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_address", {12'h0, bus_address}, {12'h0, e.addr});
                    cnt = e.ws;
                    bus_read_data = e.data;
                end
            end
            if (bus_request) begin
                if (cnt == 0) bus_ready = 1'b1;
                else begin
                    bus_ready = 1'b0;
                    cnt--;
                end
            end else begin
                bus_ready = 1'b0;
            end
            prev_req = bus_request;
        end
    end

    // queue-push monitor
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1 && q_write_enable === 1'b1) begin
                if (exp_push.size() == 0) begin
                    check("unexpected_push", {24'h0, q_write_data}, 32'hFFFFFFFF);
                end else begin
                    b = exp_push.pop_front();
                    check("push_data", {24'h0, q_write_data}, {24'h0, b});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_flush(input logic [15:0] cs, input logic [15:0] ip);
        new_cs = cs;
        new_ip = ip;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    // one fetch: queue room opened for a single IDLE cycle
    task automatic fetch(input logic [19:0] addr, input logic [15:0] data, input int ws,
                         input bit odd, input logic [15:0] exp_ip);
        int n;
        exp_bus.push_back('{addr, data, ws});
        if (!odd) exp_push.push_back(data[7:0]);
        exp_push.push_back(data[15:8]);
        q_free = 3'd6;
        tick();
        q_free = 3'd0;
        wait_idle(n);
        check("busy_cycles", n, odd ? 2 + ws : 3 + ws);
        check("fetch_ip", {16'h0, fetch_ip}, {16'h0, exp_ip});
    endtask

    initial begin
        int n;
        bit saw_req;
        reset = 1'b1;
        flush = 1'b0;
        new_cs = 16'h0000;
        new_ip = 16'h0000;
        eu_bus_request = 1'b0;
        q_free = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_bus_request", {31'h0, bus_request}, 32'h0);
        check("rst_bus_address", {12'h0, bus_address}, 32'h0);
        check("rst_q_we", {31'h0, q_write_enable}, 32'h0);
        check("rst_q_wdata", {24'h0, q_write_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_fetch_ip", {16'h0, fetch_ip}, 32'h0000);

        // FFFF:0000, zero wait states
        fetch(20'hFFFF0, 16'hBBAA, 0, 1'b0, 16'h0002);

        // odd start pushes only the high byte
        do_flush(16'h1234, 16'h0005);
        check("flush_ip", {16'h0, fetch_ip}, 32'h0005);
        fetch(20'h12344, 16'h3322, 0, 1'b1, 16'h0006);
        fetch(20'h12346, 16'h5544, 2, 1'b0, 16'h0008);

        // flush during REQUEST with 3 wait states: drained, no pushes
        exp_bus.push_back('{20'h12348, 16'h7766, 3});
        q_free = 3'd6;
        tick();
        q_free = 3'd0;
        check("req_active", {31'h0, bus_request}, 32'h1);
        do_flush(16'h2000, 16'h0100);
        n = 1;
        saw_req = 1'b1;
        while (busy === 1'b1 && n < 50) begin
            if (bus_request !== 1'b1) saw_req = 1'b0;
            tick();
            n++;
        end
        check("drain_cycles", n, 4);
        check("drain_req_held", {31'h0, saw_req}, 32'h1);
        check("drain_req_drop", {31'h0, bus_request}, 32'h0);
        check("drain_ip", {16'h0, fetch_ip}, 32'h0100);
        fetch(20'h20100, 16'h9988, 0, 1'b0, 16'h0102);

        // flush in PUSH_LO: push gated, nothing lands
        exp_bus.push_back('{20'h20102, 16'hAA99, 0});
        q_free = 3'd6;
        tick();
        q_free = 3'd0;
        tick();
        do_flush(16'hF000, 16'hFFFE);
        check("pushflush_busy", {31'h0, busy}, 32'h0);

        // segment wrap of IP, no carry into CS
        fetch(20'hFFFFE, 16'h2211, 0, 1'b0, 16'h0000);
        fetch(20'hF0000, 16'h4433, 0, 1'b0, 16'h0002);

        // no start with q_free=1, or with eu_bus_request
        saw_req = 1'b0;
        q_free = 3'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_request !== 1'b0) saw_req = 1'b1;
        end
        eu_bus_request = 1'b1;
        q_free = 3'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_request !== 1'b0) saw_req = 1'b1;
        end
        check("blocked_no_req", {31'h0, saw_req}, 32'h0);
        eu_bus_request = 1'b0;
        q_free = 3'd1;
        tick();
        exp_bus.push_back('{20'hF0002, 16'h6655, 0});
        exp_push.push_back(8'h55);
        exp_push.push_back(8'h66);
        q_free = 3'd2;
        tick();
        q_free = 3'd0;
        check("qfree2_start", {31'h0, bus_request}, 32'h1);
        wait_idle(n);
        check("qfree2_ip", {16'h0, fetch_ip}, 32'h0004);

        // 20-bit physical address wrap
        do_flush(16'hFFFF, 16'h0010);
        fetch(20'h00000, 16'h8877, 1, 1'b0, 16'h0012);

        tick();
        tick();
        check("bus_queue_empty", exp_bus.size(), 0);
        check("push_queue_empty", exp_push.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
